// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the lab CPU multi-cycle control sequencer:
// opcode values, FSM state encoding, ALU operation codes and the
// bundle of combinational control strobes driven by the sequencer.
package cpu_ctrl_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned ALU_W = 3;

    // Instruction opcodes (IR[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] OP_HALT  = 6'h3F;

    // ALU operation codes; FUNCT tells the ALU decoder to use IR funct field
    localparam logic [ALU_W-1:0] ALU_ADD   = 3'd0;
    localparam logic [ALU_W-1:0] ALU_SUB   = 3'd1;
    localparam logic [ALU_W-1:0] ALU_AND   = 3'd2;
    localparam logic [ALU_W-1:0] ALU_OR    = 3'd3;
    localparam logic [ALU_W-1:0] ALU_SLT   = 3'd4;
    localparam logic [ALU_W-1:0] ALU_FUNCT = 3'd7;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Per-cycle control strobes produced by the sequencer
    typedef struct packed {
        logic             imem_rd;
        logic             ir_load;
        logic             pc_inc;
        logic             pc_load;
        logic             pc_src;
        logic [ALU_W-1:0] alu_op;
        logic             dmem_rd;
        logic             dmem_wr;
        logic             reg_we;
    } ctrl_t;

    // ALU operation used in EXEC for a given opcode
    function automatic logic [ALU_W-1:0] alu_for_op(input logic [OP_W-1:0] op);
        logic [ALU_W-1:0] res;
        case (op)
            OP_RTYPE:       res = ALU_FUNCT;
            OP_BEQ, OP_BNE: res = ALU_SUB;
            default:        res = ALU_ADD;
        endcase
        return res;
    endfunction

    // True for every opcode the sequencer knows how to execute
    function automatic logic op_is_known(input logic [OP_W-1:0] op);
        logic res;
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE,
            OP_ADDI, OP_LW, OP_SW, OP_HALT: res = 1'b1;
            default:                        res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory handshake wait counter.
// Ports: clk, rst (sync, active-high), clr (restart count), en (count one
// not-ready cycle), at_max (registered; count has reached MAX).
// The count saturates at MAX; at_max is registered from the next count so
// it is valid in the same cycle the count holds MAX.
module ctrl_wait_timer #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned MAX   = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic at_max
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;

    // Next count: clear wins, otherwise count up to MAX and hold
    always_comb begin
        cnt_nx = cnt;
        if (clr) begin
            cnt_nx = '0;
        end else if (en && !at_max) begin
            cnt_nx = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            at_max <= (CNT_W'(MAX) == '0);
        end else begin
            cnt    <= cnt_nx;
            at_max <= (cnt_nx == CNT_W'(MAX));
        end
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the lab CPU.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, steering PC
// update, IR load, register-file write, data-memory strobes and ALU op,
// and times out stalled memory handshakes into a sticky bus error + HALT.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   opcode, zero      IR[31:26] (valid from DECODE on), ALU zero flag
//   imem_ready        instruction memory returns data this cycle
//   dmem_ready        data memory completes access this cycle
//   imem_rd, ir_load, pc_inc, pc_load, pc_src, alu_op,
//   dmem_rd, dmem_wr, reg_we
//                     combinational strobes from state + inputs, 0 in reset
//   halted            registered, 1 while in HALT
//   bus_err           registered, sticky memory-timeout flag
//   illegal           registered one-cycle pulse after an unknown opcode
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_rd,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             pc_src,
    output logic [ALU_W-1:0] alu_op,
    output logic             dmem_rd,
    output logic             dmem_wr,
    output logic             reg_we,
    output logic             halted,
    output logic             bus_err,
    output logic             illegal
);

    state_t state;
    state_t state_nx;
    ctrl_t  ctrl;

    logic timer_clr;
    logic timer_en;
    logic at_max;
    logic bus_err_set;
    logic illegal_set;

    // Wait counter restarts on every state change, counts stalled cycles
    ctrl_wait_timer #(
        .CNT_W (CNT_W),
        .MAX   (WAIT_MAX)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .en     (timer_en),
        .at_max (at_max)
    );

    assign timer_clr = (state_nx != state);

    // State and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FETCH;
            halted  <= 1'b0;
            bus_err <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state   <= state_nx;
            halted  <= (state_nx == ST_HALT);
            illegal <= illegal_set;
            if (bus_err_set) begin
                bus_err <= 1'b1;
            end
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_nx    = state;
        ctrl        = '0;
        timer_en    = 1'b0;
        bus_err_set = 1'b0;
        illegal_set = 1'b0;

        case (state)
            ST_FETCH: begin
                ctrl.imem_rd = 1'b1;
                if (imem_ready) begin
                    // Ready on the limit cycle still completes the fetch
                    ctrl.ir_load = 1'b1;
                    ctrl.pc_inc  = 1'b1;
                    state_nx     = ST_DECODE;
                end else if (at_max) begin
                    bus_err_set = 1'b1;
                    state_nx    = ST_HALT;
                end else begin
                    timer_en = 1'b1;
                end
            end

            ST_DECODE: begin
                if (opcode == OP_J) begin
                    ctrl.pc_load = 1'b1;
                    ctrl.pc_src  = 1'b1;
                    state_nx     = ST_FETCH;
                end else if (opcode == OP_HALT) begin
                    state_nx = ST_HALT;
                end else if (!op_is_known(opcode)) begin
                    // PC was already advanced in FETCH; just flag and refetch
                    illegal_set = 1'b1;
                    state_nx    = ST_FETCH;
                end else begin
                    state_nx = ST_EXEC;
                end
            end

            ST_EXEC: begin
                ctrl.alu_op = alu_for_op(opcode);
                case (opcode)
                    OP_BEQ: begin
                        ctrl.pc_load = zero;
                        state_nx     = ST_FETCH;
                    end
                    OP_BNE: begin
                        ctrl.pc_load = !zero;
                        state_nx     = ST_FETCH;
                    end
                    OP_LW, OP_SW:     state_nx = ST_MEM;
                    OP_RTYPE, OP_ADDI: state_nx = ST_WB;
                    default:          state_nx = ST_FETCH;
                endcase
            end

            ST_MEM: begin
                if (opcode == OP_SW) begin
                    ctrl.dmem_wr = 1'b1;
                end else begin
                    ctrl.dmem_rd = 1'b1;
                end
                if (dmem_ready) begin
                    state_nx = (opcode == OP_SW) ? ST_FETCH : ST_WB;
                end else if (at_max) begin
                    bus_err_set = 1'b1;
                    state_nx    = ST_HALT;
                end else begin
                    timer_en = 1'b1;
                end
            end

            ST_WB: begin
                ctrl.reg_we = 1'b1;
                state_nx    = ST_FETCH;
            end

            ST_HALT: begin
                state_nx = ST_HALT;
            end

            default: begin
                state_nx = ST_FETCH;
            end
        endcase

        // Strobes drop in the reset cycle itself
        if (rst) begin
            ctrl = '0;
        end
    end

    assign imem_rd = ctrl.imem_rd;
    assign ir_load = ctrl.ir_load;
    assign pc_inc  = ctrl.pc_inc;
    assign pc_load = ctrl.pc_load;
    assign pc_src  = ctrl.pc_src;
    assign alu_op  = ctrl.alu_op;
    assign dmem_rd = ctrl.dmem_rd;
    assign dmem_wr = ctrl.dmem_wr;
    assign reg_we  = ctrl.reg_we;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: directed vector table, randomized instruction
// stream expanded into per-cycle expectations by an instruction-level
// model, and hand-written timeout / reset / halt sequences.
module tb_cpu_ctrl_fsm;

    localparam logic [5:0] RTYPE = 6'h00;
    localparam logic [5:0] J     = 6'h02;
    localparam logic [5:0] BEQ   = 6'h04;
    localparam logic [5:0] BNE   = 6'h05;
    localparam logic [5:0] ADDI  = 6'h08;
    localparam logic [5:0] LW    = 6'h23;
    localparam logic [5:0] SW    = 6'h2B;
    localparam logic [5:0] HALT  = 6'h3F;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero, imem_ready, dmem_ready;
    logic       imem_rd, ir_load, pc_inc, pc_load, pc_src;
    logic [2:0] alu_op;
    logic       dmem_rd, dmem_wr, reg_we, halted, bus_err, illegal;

    int total = 0;
    int bad   = 0;
    bit pend_ill = 1'b0;

    typedef struct packed {
        logic       rst;
        logic [5:0] op;
        logic       z;
        logic       ir;
        logic       dr;
    } in_t;

    typedef struct packed {
        logic       imem_rd, ir_load, pc_inc, pc_load, pc_src;
        logic [2:0] alu;
        logic       dmem_rd, dmem_wr, reg_we, halted, bus_err, illegal;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t tbl[$];
    vec_t rq[$];

    cpu_ctrl_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_rd    (imem_rd),
        .ir_load    (ir_load),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .dmem_rd    (dmem_rd),
        .dmem_wr    (dmem_wr),
        .reg_we     (reg_we),
        .halted     (halted),
        .bus_err    (bus_err),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] alu_ref(input logic [5:0] op);
        if (op == RTYPE) return 3'd7;
        if (op == BEQ || op == BNE) return 3'd1;
        return 3'd0;
    endfunction

    function automatic bit known(input logic [5:0] op);
        return (op == RTYPE || op == J || op == BEQ || op == BNE ||
                op == ADDI || op == LW || op == SW || op == HALT);
    endfunction

    function automatic vec_t vv(input logic r, input logic [5:0] op, input logic z,
                                input logic ir, input logic dr, input out_t o);
        vec_t v;
        v.i.rst = r; v.i.op = op; v.i.z = z; v.i.ir = ir; v.i.dr = dr;
        v.o = o;
        return v;
    endfunction

    function automatic out_t o_fw();
        out_t o = '0;
        o.imem_rd = 1'b1;
        return o;
    endfunction

    function automatic out_t o_fh();
        out_t o = '0;
        o.imem_rd = 1'b1; o.ir_load = 1'b1; o.pc_inc = 1'b1;
        return o;
    endfunction

    function automatic out_t o_alu(input logic [5:0] op);
        out_t o = '0;
        o.alu = alu_ref(op);
        return o;
    endfunction

    function automatic out_t o_flags(input logic h, input logic be, input logic il);
        out_t o = '0;
        o.halted = h; o.bus_err = be; o.illegal = il;
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Drive one cycle of inputs, then compare all outputs mid-cycle
    task automatic apply(input vec_t v, input string tag, input int idx);
        out_t act;
        @(negedge clk);
        rst = v.i.rst; opcode = v.i.op; zero = v.i.z;
        imem_ready = v.i.ir; dmem_ready = v.i.dr;
        #1;
        act = {imem_rd, ir_load, pc_inc, pc_load, pc_src, alu_op,
               dmem_rd, dmem_wr, reg_we, halted, bus_err, illegal};
        total++;
        if (act !== v.o) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h (rst=%0b op=%h z=%0b ir=%0b dr=%0b)",
                     tag, idx, act, v.o, v.i.rst, v.i.op, v.i.z, v.i.ir, v.i.dr);
        end
    endtask

    // Expand one instruction into its expected cycle-by-cycle trace
    task automatic gen_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
        out_t o;
        for (int k = 0; k < fw; k++) begin
            o = o_fw(); o.illegal = pend_ill; pend_ill = 1'b0;
            rq.push_back(vv(1'b0, 6'($urandom), rb(), 1'b0, rb(), o));
        end
        o = o_fh(); o.illegal = pend_ill; pend_ill = 1'b0;
        rq.push_back(vv(1'b0, 6'($urandom), rb(), 1'b1, rb(), o));
        o = '0;
        if (op == J) begin o.pc_load = 1'b1; o.pc_src = 1'b1; end
        rq.push_back(vv(1'b0, op, rb(), rb(), rb(), o));
        if (!known(op)) begin pend_ill = 1'b1; return; end
        if (op == J) return;
        o = o_alu(op);
        if (op == BEQ) o.pc_load = z;
        if (op == BNE) o.pc_load = !z;
        rq.push_back(vv(1'b0, op, z, rb(), rb(), o));
        if (op == BEQ || op == BNE) return;
        if (op == LW || op == SW) begin
            o = '0; o.dmem_rd = (op == LW); o.dmem_wr = (op == SW);
            for (int k = 0; k < mw; k++) rq.push_back(vv(1'b0, op, rb(), rb(), 1'b0, o));
            rq.push_back(vv(1'b0, op, rb(), rb(), 1'b1, o));
            if (op == SW) return;
        end
        o = '0; o.reg_we = 1'b1;
        rq.push_back(vv(1'b0, op, rb(), rb(), rb(), o));
    endtask

    function automatic int rnd_wait();
        return ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
    endfunction

    function automatic logic [5:0] rnd_instr();
        logic [5:0] ops [7];
        logic [5:0] op;
        int sel;
        ops = '{RTYPE, J, BEQ, BNE, ADDI, LW, SW};
        sel = int'($urandom_range(0, 8));
        if (sel < 7) return ops[sel];
        op = 6'($urandom);
        while (known(op)) op = 6'($urandom);
        return op;
    endfunction

    initial begin
        out_t o;
        int   n;

        rst = 1'b1; opcode = '0; zero = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
        @(negedge clk);

        // Directed table: reset, ADDI, BEQ taken/not, J, LW stalled, illegal
        tbl.push_back(vv(1'b1, ADDI, 1'b0, 1'b1, 1'b1, '0));
        tbl.push_back(vv(1'b0, ADDI, 1'b0, 1'b1, 1'b1, o_fh()));
        tbl.push_back(vv(1'b0, ADDI, 1'b0, 1'b1, 1'b1, '0));
        tbl.push_back(vv(1'b0, ADDI, 1'b0, 1'b1, 1'b1, o_alu(ADDI)));
        o = '0; o.reg_we = 1'b1;
        tbl.push_back(vv(1'b0, ADDI, 1'b0, 1'b1, 1'b1, o));
        tbl.push_back(vv(1'b0, BEQ, 1'b1, 1'b1, 1'b1, o_fh()));
        tbl.push_back(vv(1'b0, BEQ, 1'b1, 1'b1, 1'b1, '0));
        o = o_alu(BEQ); o.pc_load = 1'b1;
        tbl.push_back(vv(1'b0, BEQ, 1'b1, 1'b1, 1'b1, o));
        tbl.push_back(vv(1'b0, BEQ, 1'b0, 1'b1, 1'b1, o_fh()));
        tbl.push_back(vv(1'b0, BEQ, 1'b0, 1'b1, 1'b1, '0));
        tbl.push_back(vv(1'b0, BEQ, 1'b0, 1'b1, 1'b1, o_alu(BEQ)));
        tbl.push_back(vv(1'b0, J, 1'b0, 1'b1, 1'b1, o_fh()));
        o = '0; o.pc_load = 1'b1; o.pc_src = 1'b1;
        tbl.push_back(vv(1'b0, J, 1'b0, 1'b1, 1'b1, o));
        tbl.push_back(vv(1'b0, LW, 1'b0, 1'b1, 1'b0, o_fh()));
        tbl.push_back(vv(1'b0, LW, 1'b0, 1'b1, 1'b0, '0));
        tbl.push_back(vv(1'b0, LW, 1'b0, 1'b1, 1'b0, o_alu(LW)));
        o = '0; o.dmem_rd = 1'b1;
        for (int k = 0; k < 3; k++) tbl.push_back(vv(1'b0, LW, 1'b0, 1'b1, 1'b0, o));
        tbl.push_back(vv(1'b0, LW, 1'b0, 1'b1, 1'b1, o));
        o = '0; o.reg_we = 1'b1;
        tbl.push_back(vv(1'b0, LW, 1'b0, 1'b1, 1'b0, o));
        tbl.push_back(vv(1'b0, 6'h3E, 1'b0, 1'b1, 1'b1, o_fh()));
        tbl.push_back(vv(1'b0, 6'h3E, 1'b0, 1'b1, 1'b1, '0));
        o = o_fh(); o.illegal = 1'b1;
        tbl.push_back(vv(1'b0, ADDI, 1'b0, 1'b1, 1'b1, o));
        tbl.push_back(vv(1'b0, ADDI, 1'b0, 1'b1, 1'b1, '0));
        tbl.push_back(vv(1'b0, ADDI, 1'b0, 1'b1, 1'b1, o_alu(ADDI)));
        o = '0; o.reg_we = 1'b1;
        tbl.push_back(vv(1'b0, ADDI, 1'b0, 1'b1, 1'b1, o));
        foreach (tbl[k]) apply(tbl[k], "tbl", k);

        // Random instruction stream; ends on ADDI so any illegal pulse is observed
        for (int k = 0; k < 250; k++) gen_instr(rnd_instr(), rb(), rnd_wait(), rnd_wait());
        gen_instr(ADDI, 1'b0, 0, 0);
        foreach (rq[k]) apply(rq[k], "rnd", k);

        // Fetch timeout: 16 not-ready cycles -> bus_err + HALT, sticky until rst
        n = 0;
        apply(vv(1'b1, ADDI, 1'b0, 1'b0, 1'b0, '0), "to_f", n++);
        for (int k = 0; k < 16; k++) apply(vv(1'b0, ADDI, 1'b0, 1'b0, 1'b0, o_fw()), "to_f", n++);
        for (int k = 0; k < 3; k++) apply(vv(1'b0, ADDI, 1'b0, 1'b1, 1'b1, o_flags(1, 1, 0)), "to_f", n++);
        apply(vv(1'b1, ADDI, 1'b0, 1'b1, 1'b1, o_flags(1, 1, 0)), "to_f", n++);
        apply(vv(1'b0, ADDI, 1'b0, 1'b0, 1'b0, o_fw()), "to_f", n++);

        // Ready arriving exactly at the limit completes the fetch
        n = 0;
        apply(vv(1'b1, J, 1'b0, 1'b0, 1'b0, '0), "lim_f", n++);
        for (int k = 0; k < 15; k++) apply(vv(1'b0, J, 1'b0, 1'b0, 1'b0, o_fw()), "lim_f", n++);
        apply(vv(1'b0, J, 1'b0, 1'b1, 1'b0, o_fh()), "lim_f", n++);
        o = '0; o.pc_load = 1'b1; o.pc_src = 1'b1;
        apply(vv(1'b0, J, 1'b0, 1'b0, 1'b0, o), "lim_f", n++);
        apply(vv(1'b0, J, 1'b0, 1'b0, 1'b0, o_fw()), "lim_f", n++);

        // Data-memory timeout during SW
        n = 0;
        apply(vv(1'b1, SW, 1'b0, 1'b0, 1'b0, '0), "to_m", n++);
        apply(vv(1'b0, SW, 1'b0, 1'b1, 1'b0, o_fh()), "to_m", n++);
        apply(vv(1'b0, SW, 1'b0, 1'b0, 1'b0, '0), "to_m", n++);
        apply(vv(1'b0, SW, 1'b0, 1'b0, 1'b0, o_alu(SW)), "to_m", n++);
        o = '0; o.dmem_wr = 1'b1;
        for (int k = 0; k < 16; k++) apply(vv(1'b0, SW, 1'b0, 1'b1, 1'b0, o), "to_m", n++);
        apply(vv(1'b0, SW, 1'b0, 1'b1, 1'b1, o_flags(1, 1, 0)), "to_m", n++);

        // Reset mid-MEM drops dmem_wr at once, returns to FETCH with cleared count
        n = 0;
        apply(vv(1'b1, SW, 1'b0, 1'b0, 1'b0, o_flags(1, 1, 0)), "rst_m", n++);
        apply(vv(1'b0, SW, 1'b0, 1'b1, 1'b0, o_fh()), "rst_m", n++);
        apply(vv(1'b0, SW, 1'b0, 1'b0, 1'b0, '0), "rst_m", n++);
        apply(vv(1'b0, SW, 1'b0, 1'b0, 1'b0, o_alu(SW)), "rst_m", n++);
        o = '0; o.dmem_wr = 1'b1;
        apply(vv(1'b0, SW, 1'b0, 1'b0, 1'b0, o), "rst_m", n++);
        apply(vv(1'b1, SW, 1'b0, 1'b0, 1'b0, '0), "rst_m", n++);
        for (int k = 0; k < 15; k++) apply(vv(1'b0, HALT, 1'b0, 1'b0, 1'b0, o_fw()), "rst_m", n++);
        apply(vv(1'b0, HALT, 1'b0, 1'b1, 1'b0, o_fh()), "rst_m", n++);

        // HALT opcode: halted held with all strobes low until reset
        n = 0;
        apply(vv(1'b0, HALT, 1'b0, 1'b1, 1'b1, '0), "halt", n++);
        for (int k = 0; k < 5; k++) apply(vv(1'b0, HALT, rb(), 1'b1, 1'b1, o_flags(1, 0, 0)), "halt", n++);
        apply(vv(1'b1, HALT, 1'b0, 1'b1, 1'b1, o_flags(1, 0, 0)), "halt", n++);
        apply(vv(1'b0, HALT, 1'b0, 1'b0, 1'b0, o_fw()), "halt", n++);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
